id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/riscv_pipe_pkg.sv | 15 +
 rtl/hazard_detect.sv | 18 +
 rtl/hazard_mux.sv | 15 +
 rtl/id_ex_stage.sv | 110 +++++++++++
 tb/tb_id_ex_stage.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline constants and types for the decode/execute boundary.
package riscv_pipe_pkg;

  localparam int PIPE_W     = 177;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } pipe_state_e;

  // An all-zero bundle is a no-op in execute.
  localparam logic [PIPE_W-1:0] BUBBLE_BUNDLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: an in-flight load whose destination is read by the
// instruction currently in decode.
module hazard_detect
  import riscv_pipe_pkg::*;
(
  input  logic                  ex_mem_read,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  output logic                  hit
);

  // x0 is hard-wired to zero, so a load targeting it can never feed a consumer.
  assign hit = ex_mem_read & id_valid & (ex_rd != '0) &
               ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/hazard_mux.sv
// Bubble/capture 2:1 select for the decode-to-execute bundle.
module hazard_mux
  import riscv_pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_W
) (
  input  logic             sel_bubble,
  input  logic [WIDTH-1:0] capture,
  input  logic [WIDTH-1:0] bubble,
  output logic [WIDTH-1:0] y
);

  assign y = sel_bubble ? bubble : capture;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall FSM, flush and downstream hold.
// Optional hazard performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module id_ex_stage
  import riscv_pipe_pkg::*;
#(
  parameter int WIDTH        = PIPE_W,
  parameter int STALL_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      id_bundle_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_mem_read_i,
  input  logic                  id_reg_write_i,
  input  logic                  flush_i,
  input  logic                  ex_hold_i,
  output logic [WIDTH-1:0]      ex_bundle_o,
  output logic                  ex_valid_o,
  output logic                  ex_mem_read_o,
  output logic                  ex_reg_write_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic                  stall_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           flush_cnt_o
`endif
);

  // The first stall cycle is spent in RUN, so STALL only covers the remainder.
  localparam logic [2:0] CNT_INIT = (STALL_CYCLES > 1) ? 3'(STALL_CYCLES - 2) : 3'd0;

  pipe_state_e      state_q;
  logic [2:0]       cnt_q;
  logic             hit;
  logic             bubble_sel;
  logic [WIDTH-1:0] bundle_d;

  hazard_detect u_hazard_detect (
    .ex_mem_read (ex_mem_read_o),
    .id_valid    (id_valid_i),
    .ex_rd       (ex_rd_o),
    .id_rs1      (id_rs1_i),
    .id_rs2      (id_rs2_i),
    .hit         (hit)
  );

  assign bubble_sel = flush_i | (state_q == ST_STALL) | hit;

  hazard_mux #(.WIDTH(WIDTH)) u_hazard_mux (
    .sel_bubble (bubble_sel),
    .capture    (id_bundle_i),
    .bubble     (WIDTH'(BUBBLE_BUNDLE)),
    .y          (bundle_d)
  );

  assign stall_o = !rst && !flush_i && (ex_hold_i || (state_q == ST_STALL) || hit);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_bundle_o    <= WIDTH'(BUBBLE_BUNDLE);
      ex_valid_o     <= 1'b0;
      ex_mem_read_o  <= 1'b0;
      ex_reg_write_o <= 1'b0;
      ex_rd_o        <= '0;
      state_q        <= ST_RUN;
      cnt_q          <= 3'd0;
    end else if (flush_i || !ex_hold_i) begin
      ex_bundle_o    <= bundle_d;
      ex_valid_o     <= bubble_sel ? 1'b0 : id_valid_i;
      ex_mem_read_o  <= bubble_sel ? 1'b0 : id_mem_read_i;
      ex_reg_write_o <= bubble_sel ? 1'b0 : id_reg_write_i;
      ex_rd_o        <= bubble_sel ? '0   : id_rd_i;
      if (flush_i) begin
        state_q <= ST_RUN;
        cnt_q   <= 3'd0;
      end else if (state_q == ST_STALL) begin
        if (cnt_q == 3'd0) state_q <= ST_RUN;
        else               cnt_q   <= cnt_q - 3'd1;
      end else if (hit && (STALL_CYCLES > 1)) begin
        state_q <= ST_STALL;
        cnt_q   <= CNT_INIT;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_o && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_i && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: one instance with 1 stall cycle, one with 3.
module tb_id_ex_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [176:0] id_bundle;
  logic         id_valid;
  logic [4:0]   id_rs1, id_rs2, id_rd;
  logic         id_mem_read, id_reg_write;
  logic         flush, ex_hold;

  logic [176:0] b1, b3;
  logic         v1, mr1, rw1, st1, v3, mr3, rw3, st3;
  logic [4:0]   rd1, rd3;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]  scnt1, fcnt1, scnt3, fcnt3;
`endif

  int checks = 0;
  int errors = 0;

  logic [176:0] b_cap, b_load, b_use, b_x0, b_hold;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(177), .STALL_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .id_bundle_i(id_bundle), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_mem_read_i(id_mem_read), .id_reg_write_i(id_reg_write),
    .flush_i(flush), .ex_hold_i(ex_hold),
    .ex_bundle_o(b1), .ex_valid_o(v1), .ex_mem_read_o(mr1),
    .ex_reg_write_o(rw1), .ex_rd_o(rd1), .stall_o(st1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt_o(scnt1), .flush_cnt_o(fcnt1)
`endif
  );

  id_ex_stage #(.WIDTH(177), .STALL_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .id_bundle_i(id_bundle), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_mem_read_i(id_mem_read), .id_reg_write_i(id_reg_write),
    .flush_i(flush), .ex_hold_i(ex_hold),
    .ex_bundle_o(b3), .ex_valid_o(v3), .ex_mem_read_o(mr3),
    .ex_reg_write_o(rw3), .ex_rd_o(rd3), .stall_o(st3)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt_o(scnt3), .flush_cnt_o(fcnt3)
`endif
  );

  task automatic check(input string tag, input logic [176:0] got, input logic [176:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [176:0] b, input logic v, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mr, input logic rw);
    id_bundle    = b;
    id_valid     = v;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_mem_read  = mr;
    id_reg_write = rw;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    flush   = 1'b0;
    ex_hold = 1'b0;
    drive('0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    b_cap  = {1'b1, {11{16'h1234}}};
    b_load = {1'b0, {11{16'hA5A5}}};
    b_use  = {1'b1, {11{16'h0F0F}}};
    b_x0   = {1'b0, {11{16'h5A5A}}};
    b_hold = {1'b1, {11{16'hC3C3}}};

    // Reset with live-looking inputs: outputs must still be bubbles.
    rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
    drive(b_cap, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
    #1 check("rst_stall_async", st1, 0);
    tick(); tick();
    check("rst_bundle", b1, '0);
    check("rst_valid", v1, 0);
    check("rst_mr", mr1, 0);
    check("rst_rw", rw1, 0);
    check("rst_rd", rd1, 0);
    check("rst_stall", st1, 0);
    check("rst_bundle3", b3, '0);
`ifdef HAZARD_PERF_CNT_EN
    check("rst_scnt", scnt1, 0);
    check("rst_fcnt", fcnt1, 0);
`endif

    // Plain capture
    rst = 1'b0;
    #1 check("cap_stall", st1, 0);
    tick();
    check("cap_bundle", b1, b_cap);
    check("cap_valid", v1, 1);
    check("cap_rd", rd1, 3);
    check("cap_rw", rw1, 1);
    check("cap_mr", mr1, 0);

    // Load-use with one bubble
    drive(b_load, 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    #1 check("ld_stall", st1, 0);
    tick();
    check("ld_mr", mr1, 1);
    check("ld_rd", rd1, 5);
    drive(b_use, 1'b1, 5'd7, 5'd5, 5'd6, 1'b0, 1'b1);
    #1 check("lu1_stall", st1, 1);
    tick();
    check("lu1_bubble", b1, '0);
    check("lu1_bub_valid", v1, 0);
    check("lu1_bub_rd", rd1, 0);
    check("lu1_bub_rw", rw1, 0);
    check("lu1_release", st1, 0);
    tick();
    check("lu1_capture", b1, b_use);
    check("lu1_cap_rd", rd1, 6);

    // Load-use with three bubbles
    do_reset();
    drive(b_load, 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    tick();
    drive(b_use, 1'b1, 5'd7, 5'd5, 5'd6, 1'b0, 1'b1);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("lu3_stall", st3, 1);
      tick();
      check("lu3_bubble", b3, '0);
      check("lu3_bub_valid", v3, 0);
    end
    check("lu3_release", st3, 0);
    tick();
    check("lu3_capture", b3, b_use);
    check("lu3_cap_valid", v3, 1);

    // Flush in the second stall cycle
    do_reset();
    drive(b_load, 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    tick();
    drive(b_use, 1'b1, 5'd7, 5'd5, 5'd6, 1'b0, 1'b1);
    #1 check("fl_stall1", st3, 1);
    tick();
    flush = 1'b1;
    #1 check("fl_stall_low", st3, 0);
    tick();
    check("fl_bubble", b3, '0);
    flush = 1'b0;
    #1 check("fl_after", st3, 0);
    tick();
    check("fl_capture", b3, b_use);
    check("fl_cap_rd", rd3, 6);

    // Reset in the middle of STALL
    do_reset();
    drive(b_load, 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    tick();
    drive(b_use, 1'b1, 5'd7, 5'd5, 5'd6, 1'b0, 1'b1);
    tick();
    check("rs_in_stall", st3, 1);
    rst = 1'b1;
    #1 check("rs_stall_low", st3, 0);
    tick();
`ifdef HAZARD_PERF_CNT_EN
    check("rs_scnt3", scnt3, 0);
    check("rs_fcnt3", fcnt3, 0);
`endif
    rst = 1'b0;
    #1;
    check("rs_bubble", b3, '0);
    check("rs_run", st3, 0);
    tick();
    check("rs_capture", b3, b_use);

    // x0 load never stalls; hold freezes everything
    do_reset();
    drive(b_x0, 1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1);
    tick();
    drive(b_use, 1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b1);
    #1 check("x0_stall", st1, 0);
    tick();
    check("x0_capture", b1, b_use);
    check("x0_rd", rd1, 9);
    drive(b_hold, 1'b1, 5'd3, 5'd4, 5'd10, 1'b0, 1'b1);
    ex_hold = 1'b1;
    #1 check("hold_stall", st1, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_bundle", b1, b_use);
      check("hold_rd", rd1, 9);
      check("hold_stall_on", st1, 1);
    end
    ex_hold = 1'b0;
    #1 check("hold_release", st1, 0);
    tick();
    check("hold_capture", b1, b_hold);
    check("hold_cap_rd", rd1, 10);

`ifdef HAZARD_PERF_CNT_EN
    // Two load-use hazards and one flush
    do_reset();
    check("pc_rst_scnt", scnt1, 0);
    for (int k = 0; k < 2; k++) begin
      drive(b_load, 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
      tick();
      drive(b_use, 1'b1, 5'd7, 5'd5, 5'd6, 1'b0, 1'b1);
      tick();
      tick();
    end
    drive('0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("pc_scnt", scnt1, 2);
    check("pc_fcnt", fcnt1, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
